// File: rtl/l2_sched_pkg.sv
// Shared widths, FSM state encoding and small helpers for the L2 sum-of-squares scheduler.
package l2_sched_pkg;

  localparam int DATA_W          = 8;
  localparam int ACC_W           = 20;
  localparam int MAX_LEN_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    DRAIN,
    RESP,
    CLEAR
  } state_e;

  // Width of a requester index; a single bit is kept even for one requester.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/l2_rr_arb.sv
// Combinational round-robin pick: first active request at or above ptr, wrapping.
module l2_rr_arb
  import l2_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic [IDW-1:0] cand;

  // Walk NREQ positions starting at ptr; the first active one wins.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = IDW'((int'(ptr) + off) % NREQ);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/l2_sched.sv
// Round-robin scheduler sharing one sum-of-squares datapath between NREQ vector requesters.
// One requester is granted at a time; its elements are streamed to the datapath, results
// are counted back, the final running sum is returned with the requester ID, and the
// datapath accumulator is cleared before the next grant.
module l2_sched
  import l2_sched_pkg::*;
#(
  parameter int  NREQ    = 2,
  parameter int  MAX_LEN = MAX_LEN_DEFAULT,
  localparam int IDW     = id_width(NREQ),
  localparam int CW      = $clog2(MAX_LEN) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  output logic [DATA_W-1:0]        dp_a,
  output logic                     dp_valid_in,
  output logic                     dp_clear,
  input  logic [ACC_W-1:0]         dp_f,
  input  logic                     dp_valid_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ACC_W-1:0]         rsp_data,
  output logic [IDW-1:0]           rsp_id,
  output logic                     rsp_ovf,
  output logic                     busy
);

  state_e            state_q, state_d;

  // Registered grant (index and onehot form) and round-robin start pointer.
  logic [IDW-1:0]    gnt_q;
  logic [NREQ-1:0]   gnt_oh_q;
  logic [IDW-1:0]    rr_ptr_q;
  logic [IDW-1:0]    rr_next;

  // Elements sent to / results received from the datapath for the current vector.
  logic [CW-1:0]     sent_q;
  logic [CW-1:0]     recv_q;
  logic              ovf_q;

  // Arbiter outputs.
  logic [NREQ-1:0]   arb_gnt;
  logic [IDW-1:0]    arb_idx;
  logic              arb_any;

  // Per-cycle strobes from the FSM.
  logic              hs;
  logic              ovf_hs;
  logic              at_max;
  logic              rcv_ok;
  logic              capture;
  logic              rsp_fire;

  // Granted requester's element and last flag.
  logic [DATA_W-1:0] sel_data;
  logic              sel_last;

  l2_rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign rr_next = (gnt_q == IDW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
  assign busy    = (state_q != IDLE);

  // AND-OR mux of the granted requester's element and last flag.
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_oh_q[i]) begin
        sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
        sel_last = sel_last | req_last[i];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic plus the per-cycle strobes that drive the register blocks.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    hs        = 1'b0;
    ovf_hs    = 1'b0;
    capture   = 1'b0;
    rsp_fire  = 1'b0;
    dp_clear  = 1'b0;
    at_max    = (sent_q == CW'(MAX_LEN - 1));
    // Results are only meaningful while a vector is in flight and still owed;
    // anything else is a spurious pulse and is dropped.
    rcv_ok    = dp_valid_out && (recv_q != sent_q) &&
                ((state_q == STREAM) || (state_q == DRAIN));
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        req_ready = gnt_oh_q;
        hs        = |(req_valid & gnt_oh_q);
        if (hs && (sel_last || at_max)) begin
          state_d = DRAIN;
        end
        ovf_hs = hs && at_max && !sel_last;
      end
      DRAIN: begin
        // The final result can only arrive here: it trails the last handshake by
        // the one-cycle feed register plus at least one cycle of datapath latency.
        if (rcv_ok && ((recv_q + 1'b1) == sent_q)) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_fire = 1'b1;
          state_d  = CLEAR;
        end
      end
      CLEAR: begin
        dp_clear = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Grant capture during arbitration and round-robin pointer advance after a response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_q    <= '0;
      gnt_oh_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      if ((state_q == IDLE) && arb_any) begin
        gnt_q    <= arb_idx;
        gnt_oh_q <= arb_gnt;
      end
      if (rsp_fire) begin
        rr_ptr_q <= rr_next;
      end
    end
  end

  // Sent/received element counters and the truncation flag for the current vector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sent_q <= '0;
      recv_q <= '0;
      ovf_q  <= 1'b0;
    end else if (state_q == CLEAR) begin
      sent_q <= '0;
      recv_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (hs) begin
        sent_q <= sent_q + 1'b1;
      end
      if (rcv_ok) begin
        recv_q <= recv_q + 1'b1;
      end
      if (ovf_hs) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // ---- stage p0 -> p1: datapath feed register, one cycle after each handshake ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dp_a        <= '0;
      dp_valid_in <= 1'b0;
    end else begin
      dp_valid_in <= hs;
      if (hs) begin
        dp_a <= sel_data;
      end
    end
  end

  // Response capture on the final result; held until the consumer accepts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_ovf   <= 1'b0;
    end else begin
      if (capture) begin
        rsp_valid <= 1'b1;
        rsp_data  <= dp_f;
        rsp_id    <= gnt_q;
        rsp_ovf   <= ovf_q;
      end else if (rsp_fire) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_l2_sched.sv
// Bench for l2_sched: latency-2 sum-of-squares datapath model, queue-driven requesters,
// a transaction-level scoreboard with an independent round-robin model, and literal
// expected responses for each directed scenario.
module tb_l2_sched;

  localparam int NREQ = 2;
  localparam int IDW  = 1;

  typedef struct packed {
    logic [19:0]    d;
    logic [IDW-1:0] id;
    logic           ovf;
  } rsp_t;

  logic              clk   = 1'b0;
  logic              reset = 1'b0;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        dp_a;
  logic              dp_valid_in;
  logic              dp_clear;
  logic [19:0]       dp_f;
  logic              dp_valid_out;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [19:0]       rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_ovf;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  l2_sched #(.NREQ(NREQ), .MAX_LEN(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .dp_a         (dp_a),
    .dp_valid_in  (dp_valid_in),
    .dp_clear     (dp_clear),
    .dp_f         (dp_f),
    .dp_valid_out (dp_valid_out),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_id       (rsp_id),
    .rsp_ovf      (rsp_ovf),
    .busy         (busy)
  );

  // Datapath model: two-cycle latency, running sum of squares, cleared by dp_clear.
  logic        s1_v, s2_v, spur;
  logic [7:0]  s1_a;
  logic [19:0] acc;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_v <= 1'b0; s1_a <= '0; s2_v <= 1'b0; acc <= '0; dp_f <= '0;
    end else begin
      s1_v <= dp_valid_in;
      s1_a <= dp_a;
      s2_v <= s1_v;
      if (dp_clear) begin
        acc  <= '0;
        dp_f <= '0;
      end else if (s1_v) begin
        acc  <= acc + 20'(s1_a) * 20'(s1_a);
        dp_f <= acc + 20'(s1_a) * 20'(s1_a);
      end
    end
  end
  assign dp_valid_out = s2_v | spur;

  task automatic chk_eq(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Requester stimulus: per-requester queues of {last, data}.
  logic [8:0]      sq [NREQ][$];
  logic [NREQ-1:0] gap_en = '0;
  logic            gap_ph = 1'b0;
  logic [NREQ-1:0] hs_last = '0;
  rsp_t            lit_q[$];
  rsp_t            model_q[$];
  int              rsp_cnt = 0;
  int              n_hs    = 0;

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (sq[i].size() > 0) begin
        req_valid[i]       = !(gap_en[i] && gap_ph);
        req_data[i*8 +: 8] = sq[i][0][7:0];
        req_last[i]        = sq[i][0][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[i*8 +: 8] = 8'd0;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (hs_last[i] && sq[i].size() > 0) void'(sq[i].pop_front());
    gap_ph = ~gap_ph;
    drive();
  endtask

  task automatic push(input int r, input int d, input bit l);
    sq[r].push_back({l, 8'(d)});
  endtask

  task automatic lit(input int d, input int id, input bit o);
    rsp_t t;
    t.d = 20'(d); t.id = IDW'(id); t.ovf = o;
    lit_q.push_back(t);
  endtask

  task automatic wait_rsp(input int target, input int budget);
    int n = 0;
    while (rsp_cnt < target && n < budget) begin
      step();
      n++;
    end
    chk_eq("rsp_count_in_budget", rsp_cnt, target);
  endtask

  // Round-robin reference: first requesting index at or after ptr, with wrap.
  function automatic int rr_pick(input logic [NREQ-1:0] rv, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (rv[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  // Scoreboard / per-cycle compare, sampled on the falling edge.
  int              m_ptr, m_grant, m_acc, m_cnt, pick, d;
  logic            l;
  logic [NREQ-1:0] hs;
  logic            p_hs_any, p_rsp_hs, p_rsp_pend, p_busy, p_rsp_ovf;
  logic [7:0]      p_data;
  logic [19:0]     p_rsp_data;
  logic [IDW-1:0]  p_rsp_id;
  logic [NREQ-1:0] p_rv;
  rsp_t            me, lt;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk_eq("reset_outputs_zero",
               {req_ready, dp_a, dp_valid_in, dp_clear, rsp_valid, rsp_data, rsp_id, rsp_ovf, busy}, 0);
        m_ptr = 0; m_grant = 0; m_acc = 0; m_cnt = 0;
        model_q.delete();
        p_hs_any = 0; p_rsp_hs = 0; p_rsp_pend = 0; p_busy = 0; p_rv = '0; p_data = '0;
        p_rsp_data = '0; p_rsp_id = '0; p_rsp_ovf = 0;
        hs_last = '0;
      end else begin
        if (busy && !p_busy) begin
          pick = rr_pick(p_rv, m_ptr);
          chk_eq("arb_had_request", pick >= 0, 1);
          m_grant = (pick >= 0) ? pick : 0;
        end
        if (!busy) chk_eq("idle_no_ready", req_ready, 0);
        else       chk_eq("ready_only_granted", req_ready & ~(NREQ'(1) << m_grant), 0);
        chk_eq("dp_valid_in_follows_hs", dp_valid_in, p_hs_any);
        if (p_hs_any) chk_eq("dp_a_value", dp_a, p_data);
        chk_eq("dp_clear_after_rsp", dp_clear, p_rsp_hs);
        if (p_rsp_pend) begin
          chk_eq("rsp_hold_valid", rsp_valid, 1);
          chk_eq("rsp_hold_data", rsp_data, p_rsp_data);
          chk_eq("rsp_hold_id", rsp_id, p_rsp_id);
          chk_eq("rsp_hold_ovf", rsp_ovf, p_rsp_ovf);
        end
        if (rsp_valid) begin
          chk_eq("rsp_busy", busy, 1);
          chk_eq("rsp_no_ready", req_ready, 0);
        end
        hs = req_valid & req_ready;
        if (hs != '0) begin
          d = int'(req_data[m_grant*8 +: 8]);
          l = req_last[m_grant];
          m_acc += d * d;
          m_cnt++;
          n_hs++;
          if (l || m_cnt == 16) begin
            me.d = 20'(m_acc); me.id = IDW'(m_grant); me.ovf = !l;
            model_q.push_back(me);
            m_acc = 0; m_cnt = 0;
          end
        end
        if (rsp_valid && rsp_ready) begin
          rsp_cnt++;
          chk_eq("rsp_model_pending", model_q.size() > 0, 1);
          if (model_q.size() > 0) begin
            me = model_q.pop_front();
            chk_eq("rsp_data_vs_model", rsp_data, me.d);
            chk_eq("rsp_id_vs_model", rsp_id, me.id);
            chk_eq("rsp_ovf_vs_model", rsp_ovf, me.ovf);
            if (lit_q.size() > 0) begin
              lt = lit_q.pop_front();
              chk_eq("rsp_data_literal", rsp_data, lt.d);
              chk_eq("rsp_id_literal", rsp_id, lt.id);
              chk_eq("rsp_ovf_literal", rsp_ovf, lt.ovf);
              chk_eq("model_data_literal", me.d, lt.d);
            end
          end
          m_ptr = (int'(rsp_id) + 1) % NREQ;
        end
        p_hs_any   = |hs;
        p_data     = req_data[m_grant*8 +: 8];
        p_rsp_hs   = rsp_valid && rsp_ready;
        p_rsp_pend = rsp_valid && !rsp_ready;
        p_rsp_data = rsp_data;
        p_rsp_id   = rsp_id;
        p_rsp_ovf  = rsp_ovf;
        p_busy     = busy;
        p_rv       = req_valid;
        hs_last    = hs;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int base;
  int n;

  initial begin
    req_valid = '0; req_data = '0; req_last = '0; rsp_ready = 1'b1; spur = 1'b0;
    repeat (3) step();
    reset = 1'b1;

    // Single vector 3, 4(last) from requester 0.
    push(0, 3, 0); push(0, 4, 1); lit(25, 0, 0);
    drive();
    wait_rsp(1, 100);

    // Contention from reset: both hold 1-element vectors of 2; expect ids 0,1,0,1.
    reset = 1'b0;
    step(); step();
    for (int k = 0; k < 2; k++) begin
      push(0, 2, 1); push(1, 2, 1);
    end
    lit(4, 0, 0); lit(4, 1, 0); lit(4, 0, 0); lit(4, 1, 0);
    drive();
    reset = 1'b1;
    wait_rsp(5, 200);

    // Overflow: 16 elements of 255 truncate; the 17th (marked last) is a new vector.
    for (int k = 0; k < 16; k++) push(0, 255, 0);
    push(0, 255, 1);
    lit(1040400, 0, 1); lit(65025, 0, 0);
    drive();
    wait_rsp(7, 400);

    // Back-pressure: consumer stalls 10 cycles while the response is pending.
    rsp_ready = 1'b0;
    push(0, 5, 0); push(0, 6, 1); lit(61, 0, 0);
    drive();
    n = 0;
    while (!rsp_valid && n < 100) begin
      step();
      n++;
    end
    chk_eq("bp_rsp_valid_seen", rsp_valid, 1);
    repeat (10) begin
      step();
      chk_eq("bp_busy", busy, 1);
      chk_eq("bp_req_ready", req_ready, 0);
      chk_eq("bp_dp_valid_in", dp_valid_in, 0);
      chk_eq("bp_rsp_data", rsp_data, 61);
      chk_eq("bp_rsp_id", rsp_id, 0);
    end
    rsp_ready = 1'b1;
    wait_rsp(8, 50);

    // Spurious datapath pulse while idle, then a gapped vector 1,2,3,4 from requester 1.
    step(); step();
    chk_eq("idle_before_spur", busy, 0);
    spur = 1'b1;
    step();
    spur = 1'b0;
    gap_en[1] = 1'b1;
    push(1, 1, 0); push(1, 2, 0); push(1, 3, 0); push(1, 4, 1);
    lit(30, 1, 0);
    drive();
    wait_rsp(9, 200);
    gap_en[1] = 1'b0;

    // Reset in the middle of streaming after 2 of 4 elements.
    step(); step();
    base = n_hs;
    push(0, 1, 0); push(0, 1, 0); push(0, 1, 0); push(0, 1, 1);
    drive();
    n = 0;
    while (n_hs < base + 2 && n < 50) begin
      step();
      n++;
    end
    chk_eq("mid_stream_handshakes", n_hs - base, 2);
    reset = 1'b0;
    #1;
    chk_eq("async_reset_outputs",
           {req_ready, dp_a, dp_valid_in, dp_clear, rsp_valid, rsp_data, rsp_id, rsp_ovf, busy}, 0);
    for (int i = 0; i < NREQ; i++) sq[i].delete();
    drive();
    step(); step();
    reset = 1'b1;
    push(1, 5, 1); lit(25, 1, 0);
    drive();
    wait_rsp(10, 100);

    repeat (4) step();
    chk_eq("literals_consumed", lit_q.size(), 0);
    chk_eq("model_drained", model_q.size(), 0);
    chk_eq("final_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
